dmem_dump_reader: RTL and testbench

Hardware reader for the byte-addressable data memory, and the counterpart of the file-based memory preload. After a program has run, the block sequences byte reads from the data memory starting at a programmed base address. It assembles the bytes into big-endian 32-bit words (SPARC byte order) and streams them out over a valid/ready interface, so a checker or host port can capture memory contents. It sits beside the MEM stage and shares the data memory's address and read port while the pipeline is halted.

---
 rtl/dmem_dump_reader.sv | 121 ++++++++++++
 tb/tb_dmem_dump_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader
//
// Reads the byte-addressable data memory back out after a program has run.
// Starting at a programmed base address, it fetches four bytes per word,
// packs them big-endian (lowest address in bits [31:24]), and streams the
// words out over a valid/ready handshake. It shares the data memory's
// address and read port while the pipeline is halted.
//
// Ports:
//   Clk, R       clock (rising edge), asynchronous active-low reset
//   start        begin a dump (only looked at while idle)
//   base_addr    byte address of the first word, captured on start
//   word_count   number of 32-bit words to dump, captured on start
//   mem_addr     byte address driven to the data memory
//   mem_rd_en    read strobe, high only while fetching bytes
//   mem_byte     combinational read data for mem_addr
//   out_word     assembled big-endian word
//   out_addr     byte address of out_word's most significant byte
//   out_valid    out_word/out_addr valid
//   out_ready    consumer accepts the presented word
//   busy         dump in progress (any state other than idle)
//   done         one-cycle pulse when the dump finishes
module dmem_dump_reader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_byte,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         word_q, word_d;

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    word_d      = word_q;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    out_word    = '0;
    out_addr    = '0;
    out_valid   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d       = base_addr;
          remaining_d = word_count;
          idx_d       = 2'd0;
          state_d     = (word_count == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        mem_rd_en = 1'b1;
        // Address arithmetic wraps naturally at the ADDR_W boundary.
        mem_addr  = ptr_q + ADDR_W'(idx_q);
        // Shift left so the first byte fetched ends up in bits [31:24].
        word_d    = {word_q[23:0], mem_byte};
        idx_d     = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = StPresent;
        end
      end
      StPresent: begin
        out_valid = 1'b1;
        out_addr  = ptr_q;
        out_word  = word_q;
        if (out_ready) begin
          ptr_d       = ptr_q + ADDR_W'(4);
          remaining_d = remaining_q - CNT_W'(1);
          idx_d       = 2'd0;
          state_d     = (remaining_q == CNT_W'(1)) ? StDone : StFetch;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_dump_reader.sv
module tb_dmem_dump_reader;

  logic        Clk;
  logic        R;
  logic        start;
  logic [7:0]  base_addr;
  logic [6:0]  word_count;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_byte;
  logic [31:0] out_word;
  logic [7:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  dmem_dump_reader #(
    .ADDR_W(8),
    .CNT_W (7)
  ) dut (
    .Clk       (Clk),
    .R         (R),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_byte  (mem_byte),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Data memory preloaded with mem[i] = i, read combinationally.
  logic [7:0] mem [256];
  assign mem_byte = mem[mem_addr];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_xfer   = 0;

  // Model expectations: byte addresses to be read, words/addresses to be emitted.
  logic [7:0]  exp_fetch [$];
  logic [31:0] exp_words [$];
  logic [7:0]  exp_addrs [$];
  // Observations for literal checks.
  logic [7:0]  log_fetch [$];
  logic [31:0] log_word  [$];
  logic [7:0]  log_addr  [$];

  int first_valid;
  int done_cycle;
  int busy_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A dump of n words from base reads base+0 .. base+4n-1 modulo 256 and
  // emits words {mem[a], mem[a+1], mem[a+2], mem[a+3]} with address a.
  task automatic model_push(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] a;
      logic [31:0] w;
      a = 8'((int'(b) + 4 * k) % 256);
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        logic [7:0] ba;
        ba = 8'((int'(a) + j) % 256);
        exp_fetch.push_back(ba);
        w = {w[23:0], mem[ba]};
      end
      exp_words.push_back(w);
      exp_addrs.push_back(a);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin
    if (R) begin
      if (mem_rd_en) begin
        check("rd_with_valid", {31'b0, out_valid}, 32'h0);
        if (exp_fetch.size() == 0) begin
          check("unexpected_read", {24'b0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          check("mem_addr", {24'b0, mem_addr}, {24'b0, exp_fetch.pop_front()});
          log_fetch.push_back(mem_addr);
        end
      end
      if (out_valid) begin
        if (exp_words.size() == 0) begin
          check("unexpected_valid", out_word, 32'hFFFF_FFFF);
        end else begin
          check("out_word", out_word, exp_words[0]);
          check("out_addr", {24'b0, out_addr}, {24'b0, exp_addrs[0]});
          if (out_ready) begin
            void'(exp_words.pop_front());
            void'(exp_addrs.pop_front());
            log_word.push_back(out_word);
            log_addr.push_back(out_addr);
            n_xfer++;
          end
        end
      end
      if (done) begin
        n_done++;
        check("done_words_left", exp_words.size(), 32'd0);
        check("done_reads_left", exp_fetch.size(), 32'd0);
      end
    end
  end

  task automatic clear_logs();
    log_fetch.delete();
    log_word.delete();
    log_addr.delete();
    n_xfer = 0;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [6:0] n);
    model_push(b, int'(n));
    @(posedge Clk); #1;
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    @(posedge Clk); #1;
    start      = 1'b0;
    base_addr  = 8'h55;
    word_count = 7'h2A;
  endtask

  // Run one dump; stall holds out_ready low for that many valid cycles,
  // poke pulses start with a different base while the dump is running.
  task automatic run_dump(input logic [7:0] b, input logic [6:0] n, input int stall,
                          input bit poke);
    int st;
    clear_logs();
    st          = stall;
    first_valid = 0;
    done_cycle  = 0;
    busy_cnt    = 0;
    out_ready   = (stall == 0);
    do_start(b, n);
    for (int c = 1; c <= 200; c++) begin
      @(negedge Clk);
      if (busy) busy_cnt++;
      if (out_valid && first_valid == 0) first_valid = c;
      if (done) begin
        done_cycle = c;
        break;
      end
      @(posedge Clk); #1;
      if (out_valid && st > 0) begin
        out_ready = 1'b0;
        st--;
      end else begin
        out_ready = 1'b1;
      end
      if (poke && c == 1) begin
        start      = 1'b1;
        base_addr  = 8'h80;
        word_count = 7'd5;
      end else if (poke && c == 2) begin
        start = 1'b0;
      end
    end
    check("done_seen", {31'b0, (done_cycle != 0)}, 32'd1);
    @(negedge Clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"}, {24'b0, mem_addr}, 32'd0);
    check({tag, "_mem_rd_en"}, {31'b0, mem_rd_en}, 32'd0);
    check({tag, "_out_word"}, out_word, 32'd0);
    check({tag, "_out_addr"}, {24'b0, out_addr}, 32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
  endtask

  int done_before;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    R          = 1'b0;
    start      = 1'b0;
    base_addr  = 8'h00;
    word_count = 7'd0;
    out_ready  = 1'b1;
    #23;
    check_all_zero("reset");
    @(negedge Clk);
    R = 1'b1;

    // Two words from 0, consumer always ready.
    run_dump(8'h00, 7'd2, 0, 1'b0);
    check("t1_xfers", n_xfer, 32'd2);
    check("t1_addr0", {24'b0, log_addr[0]}, 32'h00);
    check("t1_word0", log_word[0], 32'h0001_0203);
    check("t1_addr1", {24'b0, log_addr[1]}, 32'h04);
    check("t1_word1", log_word[1], 32'h0405_0607);
    check("t1_first_valid", first_valid, 32'd5);
    check("t1_done_cycle", done_cycle, 32'd11);
    check("t1_busy_cycles", busy_cnt, 32'd11);
    check("t1_done_pulses", n_done, 32'd1);

    // Address wrap across the top of memory.
    run_dump(8'hFE, 7'd1, 0, 1'b0);
    check("t2_fetch0", {24'b0, log_fetch[0]}, 32'hFE);
    check("t2_fetch1", {24'b0, log_fetch[1]}, 32'hFF);
    check("t2_fetch2", {24'b0, log_fetch[2]}, 32'h00);
    check("t2_fetch3", {24'b0, log_fetch[3]}, 32'h01);
    check("t2_word", log_word[0], 32'hFEFF_0001);
    check("t2_addr", {24'b0, log_addr[0]}, 32'hFE);

    // Backpressure: ready low for the first three valid cycles.
    run_dump(8'h20, 7'd1, 3, 1'b0);
    check("t3_xfers", n_xfer, 32'd1);
    check("t3_word", log_word[0], 32'h2021_2223);
    check("t3_reads", log_fetch.size(), 32'd4);
    check("t3_done_cycle", done_cycle, 32'd9);
    out_ready = 1'b1;

    // Zero-length dump.
    done_before = n_done;
    run_dump(8'h40, 7'd0, 0, 1'b0);
    check("t4_done_cycle", done_cycle, 32'd1);
    check("t4_busy_cycles", busy_cnt, 32'd1);
    check("t4_no_valid", first_valid, 32'd0);
    check("t4_no_reads", log_fetch.size(), 32'd0);
    check("t4_done_pulses", n_done - done_before, 32'd1);

    // Reset during the third byte fetch of the first word.
    clear_logs();
    done_before = n_done;
    do_start(8'h00, 7'd2);
    repeat (3) @(negedge Clk);
    #2;
    R = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_fetch.delete();
    exp_words.delete();
    exp_addrs.delete();
    repeat (2) @(negedge Clk);
    #2;
    R = 1'b1;
    repeat (3) @(negedge Clk);
    check("t5_no_done", n_done - done_before, 32'd0);
    check("t5_no_xfer", n_xfer, 32'd0);
    run_dump(8'h10, 7'd1, 0, 1'b0);
    check("t5_word", log_word[0], 32'h1011_1213);
    check("t5_addr", {24'b0, log_addr[0]}, 32'h10);

    // start pulsed with another base while busy must be ignored.
    run_dump(8'h30, 7'd2, 0, 1'b1);
    check("t6_xfers", n_xfer, 32'd2);
    check("t6_addr0", {24'b0, log_addr[0]}, 32'h30);
    check("t6_word1", log_word[1], 32'h3435_3637);
    check("t6_done_cycle", done_cycle, 32'd11);
    repeat (3) @(negedge Clk);
    check("t6_idle_after", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
